// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard/forwarding unit: scoreboard entry layout and FW width helper.
// Scoreboard dest fields are HZ_AW_MAX wide; REG_AW must not exceed it.
package hz_pkg;

  localparam int HZ_AW_MAX = 8;
  localparam int FWD_RF    = 0;

  typedef struct packed {
    logic                 valid;
    logic [HZ_AW_MAX-1:0] dest;
    logic                 is_load;
  } hz_entry_t;

  function automatic int hz_fw_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the ID stage (master) and the hazard scoreboard (slave).
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int STAGES = 3
) ();
  localparam int FW = hz_pkg::hz_fw_width(STAGES);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_wreg;
  logic [REG_AW-1:0] id_dest;
  logic              id_is_load;
  logic              id_md_start;
  logic              id_md_use;
  logic              flush;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic              stall;
  logic              md_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_dest,
           id_is_load, id_md_start, id_md_use, flush,
    input  fwd_a, fwd_b, stall, md_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wreg, id_dest,
           id_is_load, id_md_start, id_md_use, flush,
    output fwd_a, fwd_b, stall, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard_md_counter.sv
// Multiply/divide occupancy counter; only instantiated when HZ_MULDIV_EN is defined.
// Loaded with MD_LAT on issue, counts down to zero; busy while non-zero.
module hz_md_counter #(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_busy
);
  localparam int CW = (MD_LAT < 1) ? 1 : $clog2(MD_LAT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(MD_LAT);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_busy = (r_cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit beside decode: shift-register scoreboard of in-flight destinations,
// forwarding selects and load-use stall. HZ_MULDIV_EN adds the mult/div busy interlock.
module hazard_scoreboard
  import hz_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_STAGE = 2,
  parameter int MD_LAT     = 4
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);
  localparam int FW = hz_fw_width(STAGES);

  hz_entry_t          r_sb [1:STAGES];
  hz_entry_t          w_entry1;
  logic [STAGES:1]    w_match_a;
  logic [STAGES:1]    w_match_b;
  logic [STAGES:1]    w_ready;
  logic               w_push;
  logic               w_stall;
  logic               w_hazard;
  logic               w_md_hazard;
  logic               w_md_busy;
  logic               w_hit_a, w_hit_b, w_rdy_a, w_rdy_b;
  logic [FW-1:0]      w_sel_a, w_sel_b;
  logic [FW-1:0]      w_fwd_a, w_fwd_b;

  // Stalled or flushed instructions enter EX as bubbles; $0 writes are never tracked.
  assign w_push = bus.id_valid & bus.id_wreg & (bus.id_dest != '0) & ~w_stall & ~bus.flush;

  always_comb begin
    w_entry1 = '0;
    if (w_push) begin
      w_entry1.valid   = 1'b1;
      w_entry1.dest    = HZ_AW_MAX'(bus.id_dest);
      w_entry1.is_load = bus.id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_sb[1] <= '0;
    else     r_sb[1] <= w_entry1;
  end

  genvar gi;
  generate
    for (gi = 2; gi <= STAGES; gi++) begin : g_shift
      always_ff @(posedge clk) begin
        if (rst) r_sb[gi] <= '0;
        else     r_sb[gi] <= r_sb[gi-1];
      end
    end

    for (gi = 1; gi <= STAGES; gi++) begin : g_match
      assign w_ready[gi]   = (gi >= LOAD_STAGE) ? 1'b1 : ~r_sb[gi].is_load;
      assign w_match_a[gi] = bus.id_use_rs & (bus.id_rs != '0) & r_sb[gi].valid &
                             (r_sb[gi].dest == HZ_AW_MAX'(bus.id_rs));
      assign w_match_b[gi] = bus.id_use_rt & (bus.id_rt != '0) & r_sb[gi].valid &
                             (r_sb[gi].dest == HZ_AW_MAX'(bus.id_rt));
    end
  endgenerate

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    w_rdy_a = 1'b0;
    w_rdy_b = 1'b0;
    w_sel_a = FW'(FWD_RF);
    w_sel_b = FW'(FWD_RF);
    for (int k = STAGES; k >= 1; k--) begin
      if (w_match_a[k]) begin
        w_hit_a = 1'b1;
        w_rdy_a = w_ready[k];
        w_sel_a = FW'(k);
      end
      if (w_match_b[k]) begin
        w_hit_b = 1'b1;
        w_rdy_b = w_ready[k];
        w_sel_b = FW'(k);
      end
    end
    w_fwd_a  = (w_hit_a & w_rdy_a) ? w_sel_a : FW'(FWD_RF);
    w_fwd_b  = (w_hit_b & w_rdy_b) ? w_sel_b : FW'(FWD_RF);
    w_hazard = (w_hit_a & ~w_rdy_a) | (w_hit_b & ~w_rdy_b);
  end

`ifdef HZ_MULDIV_EN
  hz_md_counter #(
    .MD_LAT (MD_LAT)
  ) u_md_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (bus.id_valid & bus.id_md_start & ~w_stall & ~bus.flush),
    .o_busy (w_md_busy)
  );
  assign w_md_hazard = w_md_busy & (bus.id_md_start | bus.id_md_use);
`else
  logic w_unused_md;
  assign w_unused_md = bus.id_md_start | bus.id_md_use;
  assign w_md_busy   = 1'b0;
  assign w_md_hazard = 1'b0;
`endif

  assign w_stall     = bus.id_valid & ~bus.flush & (w_hazard | w_md_hazard);
  assign bus.stall   = w_stall;
  assign bus.fwd_a   = w_fwd_a;
  assign bus.fwd_b   = w_fwd_b;
  assign bus.md_busy = w_md_busy;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: LOAD_STAGE=2 unit (bus0) plus a LOAD_STAGE=3 unit (bus1) driven in lockstep.
// The mult/div scenario checks the interlock when HZ_MULDIV_EN is defined, inert ports otherwise.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5), .STAGES(3)) bus0 ();
  hazard_scoreboard_if #(.REG_AW(5), .STAGES(3)) bus1 ();

  hazard_scoreboard #(.REG_AW(5), .STAGES(3), .LOAD_STAGE(2), .MD_LAT(4)) dut0 (
    .clk (clk), .rst (rst), .bus (bus0)
  );
  hazard_scoreboard #(.REG_AW(5), .STAGES(3), .LOAD_STAGE(3), .MD_LAT(4)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wreg,
                       input logic [4:0] dest, input logic ld, input logic mds,
                       input logic mdu, input logic fl);
    bus0.id_valid = v;   bus1.id_valid = v;
    bus0.id_rs = rs;     bus1.id_rs = rs;
    bus0.id_rt = rt;     bus1.id_rt = rt;
    bus0.id_use_rs = urs; bus1.id_use_rs = urs;
    bus0.id_use_rt = urt; bus1.id_use_rt = urt;
    bus0.id_wreg = wreg; bus1.id_wreg = wreg;
    bus0.id_dest = dest; bus1.id_dest = dest;
    bus0.id_is_load = ld; bus1.id_is_load = ld;
    bus0.id_md_start = mds; bus1.id_md_start = mds;
    bus0.id_md_use = mdu; bus1.id_md_use = mdu;
    bus0.flush = fl;     bus1.flush = fl;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nop();
    repeat (2) tick();
    rst = 1'b0;
    sample();
    chk_cnt++; if (bus0.fwd_a !== 2'd0) $display("FAIL reset_fwd_a: got %0d expected 0", bus0.fwd_a); else pass_cnt++;
    chk_cnt++; if (bus0.fwd_b !== 2'd0) $display("FAIL reset_fwd_b: got %0d expected 0", bus0.fwd_b); else pass_cnt++;
    chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL reset_stall: got %0b expected 0", bus0.stall); else pass_cnt++;
    chk_cnt++; if (bus0.md_busy !== 1'b0) $display("FAIL reset_md_busy: got %0b expected 0", bus0.md_busy); else pass_cnt++;
    $display("test_reset done");
    tick();
  endtask

  task automatic test_alu_chain();
    logic [1:0] exp_fwd;
    drain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);   // add $3,$1,$2
    sample();
    chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL alu_producer_stall: got %0b expected 0", bus0.stall); else pass_cnt++;
    tick();
    for (int c = 1; c <= 4; c++) begin
      exp_fwd = (c == 4) ? 2'd0 : 2'(c);
      drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0); // add $4,$3,$3
      sample();
      chk_cnt++; if (bus0.fwd_a !== exp_fwd) $display("FAIL alu_fwd_a_c%0d: got %0d expected %0d", c, bus0.fwd_a, exp_fwd); else pass_cnt++;
      chk_cnt++; if (bus0.fwd_b !== exp_fwd) $display("FAIL alu_fwd_b_c%0d: got %0d expected %0d", c, bus0.fwd_b, exp_fwd); else pass_cnt++;
      chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL alu_stall_c%0d: got %0b expected 0", c, bus0.stall); else pass_cnt++;
      tick();
    end
    $display("test_alu_chain done");
  endtask

  task automatic test_load_use();
    logic       exp_s0 [3];
    logic       exp_s1 [3];
    logic [1:0] exp_f0 [3];
    logic [1:0] exp_f1 [3];
    exp_s0 = '{1'b1, 1'b0, 1'b0};  exp_f0 = '{2'd0, 2'd2, 2'd3};
    exp_s1 = '{1'b1, 1'b1, 1'b0};  exp_f1 = '{2'd0, 2'd0, 2'd3};
    drain();
    drive(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); // lw $5
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0); // add $6,$5,$0
      sample();
      chk_cnt++; if (bus0.stall !== exp_s0[c]) $display("FAIL ld2_stall_c%0d: got %0b expected %0b", c, bus0.stall, exp_s0[c]); else pass_cnt++;
      chk_cnt++; if (bus0.fwd_a !== exp_f0[c]) $display("FAIL ld2_fwd_a_c%0d: got %0d expected %0d", c, bus0.fwd_a, exp_f0[c]); else pass_cnt++;
      chk_cnt++; if (bus0.fwd_b !== 2'd0) $display("FAIL ld2_fwd_b_c%0d: got %0d expected 0", c, bus0.fwd_b); else pass_cnt++;
      chk_cnt++; if (bus1.stall !== exp_s1[c]) $display("FAIL ld3_stall_c%0d: got %0b expected %0b", c, bus1.stall, exp_s1[c]); else pass_cnt++;
      chk_cnt++; if (bus1.fwd_a !== exp_f1[c]) $display("FAIL ld3_fwd_a_c%0d: got %0d expected %0d", c, bus1.fwd_a, exp_f1[c]); else pass_cnt++;
      tick();
    end
    $display("test_load_use done");
  endtask

  task automatic test_youngest_wins();
    drain();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);  // addi $7
    tick();
    drive(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); // lw $7
    tick();
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);  // reader of $7
    sample();
    chk_cnt++; if (bus0.stall !== 1'b1) $display("FAIL young_stall: got %0b expected 1", bus0.stall); else pass_cnt++;
    chk_cnt++; if (bus0.fwd_a !== 2'd0) $display("FAIL young_fwd_a: got %0d expected 0", bus0.fwd_a); else pass_cnt++;
    tick();
    sample();
    chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL young_after_stall: got %0b expected 0", bus0.stall); else pass_cnt++;
    chk_cnt++; if (bus0.fwd_a !== 2'd2) $display("FAIL young_after_fwd_a: got %0d expected 2", bus0.fwd_a); else pass_cnt++;
    tick();
    $display("test_youngest_wins done");
  endtask

  task automatic test_flush();
    drain();
    drive(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0); // lw $8
    tick();
    drive(1'b1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1);  // reader, flushed
    sample();
    chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL flush_stall: got %0b expected 0", bus0.stall); else pass_cnt++;
    tick();
    drive(1'b1, 5'd9, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);  // reads $9 and $8
    sample();
    chk_cnt++; if (bus0.fwd_a !== 2'd0) $display("FAIL flush_bubble_fwd_a: got %0d expected 0", bus0.fwd_a); else pass_cnt++;
    chk_cnt++; if (bus0.fwd_b !== 2'd2) $display("FAIL flush_load_fwd_b: got %0d expected 2", bus0.fwd_b); else pass_cnt++;
    chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL flush_after_stall: got %0b expected 0", bus0.stall); else pass_cnt++;
    tick();
    $display("test_flush done");
  endtask

  task automatic test_reg0_and_invalid();
    drain();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);  // write $0
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk_cnt++; if (bus0.fwd_a !== 2'd0) $display("FAIL reg0_fwd_a: got %0d expected 0", bus0.fwd_a); else pass_cnt++;
    chk_cnt++; if (bus0.fwd_b !== 2'd0) $display("FAIL reg0_fwd_b: got %0d expected 0", bus0.fwd_b); else pass_cnt++;
    tick();
    drive(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0); // lw $10
    tick();
    drive(1'b0, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);  // not a real instr
    sample();
    chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL invalid_stall: got %0b expected 0", bus0.stall); else pass_cnt++;
    tick();
    $display("test_reg0_and_invalid done");
  endtask

  task automatic test_reset_during_stall();
    drain();
    drive(1'b1, 5'd29, 5'd0, 1'b1, 1'b0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0); // lw $11
    tick();
    drive(1'b1, 5'd11, 5'd0, 1'b1, 1'b0, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0);
    sample();
    chk_cnt++; if (bus0.stall !== 1'b1) $display("FAIL rststall_pre: got %0b expected 1", bus0.stall); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sample();
    chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL rststall_post: got %0b expected 0", bus0.stall); else pass_cnt++;
    chk_cnt++; if (bus0.fwd_a !== 2'd0) $display("FAIL rststall_fwd_a: got %0d expected 0", bus0.fwd_a); else pass_cnt++;
    tick();
    $display("test_reset_during_stall done");
  endtask

  task automatic test_muldiv();
    drain();
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);  // mult $1,$2
    sample();
    chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL md_mult_stall: got %0b expected 0", bus0.stall); else pass_cnt++;
    tick();
`ifdef HZ_MULDIV_EN
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0); // mfhi $13
      sample();
      chk_cnt++; if (bus0.stall !== 1'b1) $display("FAIL md_mfhi_stall_c%0d: got %0b expected 1", c, bus0.stall); else pass_cnt++;
      chk_cnt++; if (bus0.md_busy !== 1'b1) $display("FAIL md_busy_c%0d: got %0b expected 1", c, bus0.md_busy); else pass_cnt++;
      tick();
    end
`endif
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0);   // mfhi issues
    sample();
    chk_cnt++; if (bus0.stall !== 1'b0) $display("FAIL md_mfhi_issue_stall: got %0b expected 0", bus0.stall); else pass_cnt++;
    chk_cnt++; if (bus0.md_busy !== 1'b0) $display("FAIL md_busy_issue: got %0b expected 0", bus0.md_busy); else pass_cnt++;
    tick();
    nop();
    sample();
    chk_cnt++; if (bus0.md_busy !== 1'b0) $display("FAIL md_busy_after: got %0b expected 0", bus0.md_busy); else pass_cnt++;
    tick();
    $display("test_muldiv done");
  endtask

  initial begin
    nop();
    #1;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest_wins();
    test_flush();
    test_reg0_and_invalid();
    test_reset_during_stall();
    test_muldiv();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
